mem_arbiter: RTL

Two-port main-memory arbiter and access sequencer placed between the instruction-cache and data-cache miss engines and the single shared main memory. It accepts one read or write request at a time from either cache and drives the memory strobes and address for a fixed latency. It returns read data with a one-cycle done pulse. It replaces the per-cache read-latency counter, so both caches share one memory port without collision.

---
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Shared main-memory arbiter: grants one cache miss engine at a time and holds the strobes for MEM_LAT cycles.
// Tie policy: define MEM_ARB_RR_EN for round-robin; otherwise the data side always wins ties.
module mem_arbiter #(
  parameter int MEM_LAT = 2,
  parameter int AW      = 32,
  parameter int DW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_rd,
  input  logic          i_wr,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_wdata,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          i_done,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic [1:0]    gnt,
  output logic          busy,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rd,
  output logic          mem_wr,
  input  logic [DW-1:0] mem_rdata,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_owner;
  logic          r_i_done;
  logic          r_d_done;
  logic [DW-1:0] r_rdata;
  logic [1:0]    r_gnt;
  logic          r_busy;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_rd;
  logic          r_mem_wr;
  logic          r_err;

  logic          w_i_req;
  logic          w_d_req;
  logic          w_pick_d;
  logic          w_wr_sel;
  logic          w_both;
  logic [AW-1:0] w_addr_sel;
  logic [DW-1:0] w_wdata_sel;

  assign w_i_req = i_rd | i_wr;
  assign w_d_req = d_rd | d_wr;

`ifdef MEM_ARB_RR_EN
  // r_last holds the most recent owner (0 = i, 1 = d); on a tie the other side wins.
  logic r_last;
  assign w_pick_d = w_d_req & (~w_i_req | ~r_last);
`else
  assign w_pick_d = w_d_req;
`endif

  // rd together with wr is executed as a write.
  assign w_wr_sel    = w_pick_d ? d_wr : i_wr;
  assign w_addr_sel  = w_pick_d ? d_addr : i_addr;
  assign w_wdata_sel = w_pick_d ? d_wdata : i_wdata;
  assign w_both      = (i_rd & i_wr) | (d_rd & d_wr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= 4'd0;
      r_owner     <= 1'b0;
      r_i_done    <= 1'b0;
      r_d_done    <= 1'b0;
      r_rdata     <= '0;
      r_gnt       <= 2'b00;
      r_busy      <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_err       <= 1'b0;
`ifdef MEM_ARB_RR_EN
      r_last      <= 1'b1;
`endif
    end else begin
      r_i_done <= 1'b0;
      r_d_done <= 1'b0;
      if (w_both) begin
        r_err <= 1'b1;
      end
      case (r_state)
        S_IDLE: begin
          if (w_i_req | w_d_req) begin
            r_owner     <= w_pick_d;
            r_gnt       <= w_pick_d ? 2'b10 : 2'b01;
            r_mem_addr  <= w_addr_sel;
            r_mem_wdata <= w_wdata_sel;
            r_mem_rd    <= ~w_wr_sel;
            r_mem_wr    <= w_wr_sel;
            r_cnt       <= 4'd0;
            r_busy      <= 1'b1;
            r_state     <= S_BUSY;
`ifdef MEM_ARB_RR_EN
            r_last      <= w_pick_d;
`endif
          end
        end
        S_BUSY: begin
          if (r_cnt == CNT_LAST) begin
            if (r_mem_rd) begin
              r_rdata <= mem_rdata;
            end
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_i_done <= ~r_owner;
            r_d_done <= r_owner;
            r_state  <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        S_DONE: begin
          r_gnt   <= 2'b00;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign i_done    = r_i_done;
  assign d_done    = r_d_done;
  assign rdata     = r_rdata;
  assign gnt       = r_gnt;
  assign busy      = r_busy;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_rd    = r_mem_rd;
  assign mem_wr    = r_mem_wr;
  assign err       = r_err;

endmodule
